// File: rtl/dcache.sv
// dcache: direct-mapped, write-through, no-write-allocate data cache.
// One NBITS-wide word per line; index = low $clog2(NLINES) address bits,
// tag = the remaining upper bits. Read hits complete with no stall.
// Optional feature macro: DCACHE_STATS_EN adds 16-bit saturating hit/miss
// counters (ports hits, misses).
//
// Handshakes:
//   Controller side: a request (MemRead/MemWrite with addr/wdata) is live
//   while asserted; it retires in the first cycle busy is low, and
//   MemRead/MemWrite/addr/wdata must stay stable while busy is high.
//   Memory side: mem_req (qualified by mem_we) is held continuously until a
//   single-cycle mem_ack; mem_rdata is valid only with mem_ack.
module dcache #(
  parameter int NBITS  = 8,
  parameter int NLINES = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [NBITS-1:0] addr,
  input  logic [NBITS-1:0] wdata,
  output logic [NBITS-1:0] rdata,
  output logic             busy,
  output logic             mem_req,
  output logic             mem_we,
  output logic [NBITS-1:0] mem_addr,
  output logic [NBITS-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [NBITS-1:0] mem_rdata,
`ifdef DCACHE_STATS_EN
  output logic [15:0]      hits,
  output logic [15:0]      misses,
`endif
  output logic [1:0]       state_dbg
);

  localparam int IDXW = $clog2(NLINES);
  localparam int TAGW = NBITS - IDXW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RMISS = 2'd1,
    WTHRU = 2'd2
  } state_t;

  state_t state;

  logic [NLINES-1:0] line_valid;
  logic [TAGW-1:0]   line_tag  [NLINES];
  logic [NBITS-1:0]  line_data [NLINES];

  logic [IDXW-1:0] idx;
  logic [TAGW-1:0] req_tag;
  logic            hit;

  assign idx       = addr[IDXW-1:0];
  assign req_tag   = addr[NBITS-1:IDXW];
  assign hit       = line_valid[idx] && (line_tag[idx] == req_tag);
  assign state_dbg = state;

  // Stall and read-data decode: hits return line data the same cycle; a
  // store retires on the ack cycle itself.
  always_comb begin
    rdata = '0;
    busy  = 1'b0;
    if (hit) rdata = line_data[idx];
    case (state)
      IDLE:    busy = MemWrite || (MemRead && !hit);
      RMISS:   busy = 1'b1;
      WTHRU:   busy = !mem_ack;
      default: busy = 1'b0;
    endcase
  end

  // Control FSM with registered backing-memory request outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MemWrite) begin
            state     <= WTHRU;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= wdata;
          end else if (MemRead && !hit) begin
            state    <= RMISS;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= addr;
          end
        end
        RMISS, WTHRU: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Valid bits: cleared by reset, set when a miss fill lands.
  always_ff @(posedge clock) begin
    if (reset) line_valid <= '0;
    else if (state == RMISS && mem_ack) line_valid[idx] <= 1'b1;
  end

  // Tag/data arrays: fill on read miss, update on write-through hit only.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == RMISS && mem_ack) begin
        line_tag[idx]  <= req_tag;
        line_data[idx] <= mem_rdata;
      end else if (state == WTHRU && mem_ack && hit) begin
        line_data[idx] <= wdata;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  // Saturating counters: retiring read hits and IDLE->RMISS transitions.
  always_ff @(posedge clock) begin
    if (reset) begin
      hits   <= '0;
      misses <= '0;
    end else if (state == IDLE && MemRead && !MemWrite) begin
      if (hit) begin
        if (hits != 16'hFFFF) hits <= hits + 16'd1;
      end else begin
        if (misses != 16'hFFFF) misses <= misses + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache.sv
// tb_dcache: randomized self-checking bench for dcache. The reference model
// tracks which full address owns each line and the expected memory image;
// a cached read must always return the expected memory word.
module tb_dcache;

  localparam int NBITS  = 8;
  localparam int NLINES = 8;

  // ---------------- clock / reset ----------------
  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             MemRead = 1'b0;
  logic             MemWrite = 1'b0;
  logic [NBITS-1:0] addr = '0;
  logic [NBITS-1:0] wdata = '0;
  logic [NBITS-1:0] rdata;
  logic             busy;
  logic             mem_req;
  logic             mem_we;
  logic [NBITS-1:0] mem_addr;
  logic [NBITS-1:0] mem_wdata;
  logic             mem_ack = 1'b0;
  logic [NBITS-1:0] mem_rdata = '0;
  logic [1:0]       state_dbg;
`ifdef DCACHE_STATS_EN
  logic [15:0]      hits;
  logic [15:0]      misses;
`endif

  always #5 clock = ~clock;

  dcache #(.NBITS(NBITS), .NLINES(NLINES)) dut (
    .clock     (clock),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
`ifdef DCACHE_STATS_EN
    .hits      (hits),
    .misses    (misses),
`endif
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;

  logic [NBITS-1:0] ref_mem [256];   // expected memory image
  logic [NBITS-1:0] bmem    [256];   // backing memory written via DUT port
  bit               own_v   [NLINES];
  logic [NBITS-1:0] own_a   [NLINES];
  int               exp_hits = 0;
  int               exp_misses = 0;
  logic [NBITS-1:0] exp_q [$];       // expected read data, in retire order

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- backing memory responder ----------------
  int lat_cur = 1;
  int rcnt = 0;
  bit inject_ack = 1'b0;

  always @(posedge clock) begin
    #2;
    mem_ack = inject_ack;
    if (inject_ack) mem_rdata = NBITS'($urandom);
    if (reset || !mem_req) begin
      rcnt = 0;
    end else begin
      rcnt++;
      if (rcnt >= lat_cur) begin
        mem_ack = 1'b1;
        rcnt = 0;
        if (mem_we) bmem[mem_addr] = mem_wdata;
        else mem_rdata = bmem[mem_addr];
      end
    end
  end

  // ---------------- request-stability monitor ----------------
  logic        mon_busy = 1'b0;
  logic        mon_rst = 1'b1;
  logic [17:0] mon_snap = '0;

  always @(negedge clock) begin
    if (mon_busy && !reset && !mon_rst)
      chk("req_stable", {14'd0, MemRead, MemWrite, addr, wdata} & 32'h3FFFF, {14'd0, mon_snap});
    mon_busy = busy;
    mon_rst  = reset;
    mon_snap = {MemRead, MemWrite, addr, wdata};
  end

  // ---------------- driver tasks ----------------
  task automatic check_stats();
`ifdef DCACHE_STATS_EN
    chk("hits", {16'd0, hits}, exp_hits);
    chk("misses", {16'd0, misses}, exp_misses);
`endif
  endtask

  // Drive one read; entered and left at posedge+1.
  task automatic do_read(input logic [NBITS-1:0] a, input int lat);
    bit exp_hit, done, seen;
    int stall, ix;
    logic [NBITS-1:0] s_addr;
    logic s_we;
    ix = int'(a) % NLINES;
    exp_hit = own_v[ix] && (own_a[ix] == a);
    lat_cur = lat;
    MemRead = 1'b1; MemWrite = 1'b0; addr = a; wdata = NBITS'($urandom);
    stall = 0; done = 0; seen = 0; s_addr = '0; s_we = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clock);
      if (mem_req && !seen) begin seen = 1; s_addr = mem_addr; s_we = mem_we; end
      if (!busy) begin done = 1; break; end
      stall++;
      @(posedge clock); #1;
    end
    if (!done) begin
      chk("rd_timeout", 1, 0);
    end else begin
      exp_q.push_back(ref_mem[a]);
      chk("rd_stall", stall, exp_hit ? 0 : 1 + lat);
      chk("rd_data", {24'd0, rdata}, {24'd0, exp_q.pop_front()});
      chk("rd_memreq", {31'd0, seen}, {31'd0, !exp_hit});
      if (seen) begin
        chk("rd_memaddr", {24'd0, s_addr}, {24'd0, a});
        chk("rd_memwe", {31'd0, s_we}, 0);
      end
      own_v[ix] = 1; own_a[ix] = a;
      exp_hits++;
      if (!exp_hit) exp_misses++;
    end
    @(posedge clock); #1;
    MemRead = 1'b0;
    check_stats();
  endtask

  // Drive one write (optionally with MemRead also high).
  task automatic do_write(input logic [NBITS-1:0] a, input logic [NBITS-1:0] d,
                          input int lat, input bit both);
    bit done, seen;
    int stall;
    logic [NBITS-1:0] s_addr, s_wd;
    logic s_we;
    lat_cur = lat;
    MemRead = both; MemWrite = 1'b1; addr = a; wdata = d;
    stall = 0; done = 0; seen = 0; s_addr = '0; s_wd = '0; s_we = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clock);
      if (mem_req && !seen) begin seen = 1; s_addr = mem_addr; s_we = mem_we; s_wd = mem_wdata; end
      if (!busy) begin done = 1; break; end
      stall++;
      @(posedge clock); #1;
    end
    if (!done) begin
      chk("wr_timeout", 1, 0);
    end else begin
      chk("wr_stall", stall, lat);
      chk("wr_memreq", {31'd0, seen}, 1);
      chk("wr_memwe", {31'd0, s_we}, 1);
      chk("wr_memaddr", {24'd0, s_addr}, {24'd0, a});
      chk("wr_memwdata", {24'd0, s_wd}, {24'd0, d});
      ref_mem[a] = d;
    end
    @(posedge clock); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    check_stats();
  endtask

  task automatic clear_model();
    for (int i = 0; i < NLINES; i++) own_v[i] = 0;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge clock);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_memreq"}, {31'd0, mem_req}, 0);
    chk({tag, "_rdata"}, {24'd0, rdata}, 0);
    @(posedge clock); #1;
  endtask

  // ---------------- main sequence ----------------
  logic [NBITS-1:0] pool [12];

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [NBITS-1:0] v;
      v = NBITS'($urandom);
      ref_mem[i] = v;
      bmem[i] = v;
    end
    ref_mem[8'h13] = 8'hA5; bmem[8'h13] = 8'hA5;
    clear_model();

    // reset values
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_memreq", {31'd0, mem_req}, 0);
    chk("rst_memwe", {31'd0, mem_we}, 0);
    chk("rst_memaddr", {24'd0, mem_addr}, 0);
    chk("rst_memwdata", {24'd0, mem_wdata}, 0);
    chk("rst_rdata", {24'd0, rdata}, 0);
    check_stats();
    @(posedge clock); #1;

    // cold read, then repeat hit
    do_read(8'h13, 2);
    do_read(8'h13, 2);
    // conflict eviction on index 3
    do_read(8'h23, 3);
    do_read(8'h13, 1);
    // write-through hit, then hit returns new data
    do_write(8'h13, 8'h5A, 2, 0);
    do_read(8'h13, 2);
    // write miss, no allocate
    do_write(8'h40, 8'h77, 3, 0);
    do_read(8'h40, 2);
    // simultaneous read+write treated as write
    do_write(8'h02, 8'h3C, 1, 1);
    do_read(8'h02, 1);
    // wrap-around address
    do_read(8'hFF, 4);
    do_read(8'hFF, 1);

    // reset during RMISS, then a stray ack
    lat_cur = 20;
    MemRead = 1'b1; addr = 8'h33;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1; MemRead = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0; inject_ack = 1'b1;
    clear_model();
    @(negedge clock);
    chk("rstmid_memreq", {31'd0, mem_req}, 0);
    chk("rstmid_busy", {31'd0, busy}, 0);
    @(posedge clock); #1;
    inject_ack = 1'b0;
    check_idle_outputs("stray_ack");
    check_stats();

    // previously cached 8'h13 now misses; then 3 more hits
    do_read(8'h13, 2);
    do_read(8'h13, 1);
    do_read(8'h13, 1);
    do_read(8'h13, 1);
`ifdef DCACHE_STATS_EN
    chk("stats_misses_directed", {16'd0, misses}, 1);
    chk("stats_hits_directed", {16'd0, hits}, 4);
`endif

    // randomized traffic over a small address pool to force reuse/conflicts
    for (int i = 0; i < 10; i++) pool[i] = NBITS'($urandom);
    pool[10] = 8'hFF;
    pool[11] = 8'h00;
    for (int n = 0; n < 300; n++) begin
      logic [NBITS-1:0] a;
      int lat;
      a = ($urandom_range(0, 4) == 0) ? NBITS'($urandom_range(0, 255))
                                      : pool[$urandom_range(0, 11)];
      lat = $urandom_range(1, 4);
      if ($urandom_range(0, 9) < 6) do_read(a, lat);
      else do_write(a, NBITS'($urandom), lat, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock); #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global time bound
  initial begin
    #500000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
